// File: rtl/pkt_buffer_writer.sv
// pkt_buffer_writer: stores ingress packets into 32-flit slots keyed by a popped free ID
// and emits one descriptor per packet.
package pkt_buffer_writer_pkg;
    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } flit_t;

    localparam logic [3:0] PKT_ETH  = 4'd1;
    localparam logic [3:0] PKT_DROP = 4'd2;

    typedef struct packed {
        logic [15:0] pktID;
        logic [5:0]  flits;
        logic [15:0] len;
        logic [3:0]  pkt_flags;
        logic [31:0] timestamp;
        logic [15:0] port;
    } metadata_t;
endpackage

module pkt_buffer_writer
    import pkt_buffer_writer_pkg::*;
#(
    parameter int PKT_AWIDTH    = 9,
    parameter int PKTBUF_AWIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_pkt_valid,
    input  logic                     in_pkt_sop,
    input  logic                     in_pkt_eop,
    input  logic [511:0]             in_pkt_data,
    input  logic [5:0]               in_pkt_empty,
    output logic                     in_pkt_ready,
    input  logic [PKT_AWIDTH-1:0]    emptylist_out_data,
    input  logic                     emptylist_out_valid,
    output logic                     emptylist_out_ready,
    output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
    output logic                     pkt_buffer_write,
    output flit_t                    pkt_buffer_writedata,
    output logic                     meta_valid,
    output metadata_t                meta_data,
    input  logic                     meta_ready
);
    typedef enum logic [1:0] {WAIT_ID, WAIT_SOP, BODY} state_t;

    state_t                state;
    logic [PKT_AWIDTH-1:0] cur_id;
    logic [4:0]            flit_idx;
    logic                  full;
    logic                  truncated;
    logic                  accept, start, wr, done, trunc;
    logic [4:0]            widx;
    logic [5:0]            stored, n;
    metadata_t             meta_next;

    assign emptylist_out_ready = !rst && state == WAIT_ID;
    assign in_pkt_ready        = !rst && state != WAIT_ID && !meta_valid;

    // full marks that slot index 31 has been written; flit_idx then stops counting
    always_comb begin
        accept = in_pkt_valid && in_pkt_ready;
        start  = accept && state == WAIT_SOP && in_pkt_sop;
        wr     = start || (accept && state == BODY && !full);
        done   = (start || (accept && state == BODY)) && in_pkt_eop;
        widx   = start ? 5'd0 : flit_idx;
        stored = full ? 6'd32 : {1'b0, flit_idx};
        n      = start ? 6'd1 : stored + {5'd0, !full};
        trunc  = !start && (truncated || full);
        meta_next           = '0;
        meta_next.pktID     = 16'(cur_id);
        meta_next.flits     = n;
        meta_next.len       = trunc ? 16'd2048 : 16'({n, 6'd0}) - {10'd0, in_pkt_empty};
        meta_next.pkt_flags = trunc ? PKT_DROP : PKT_ETH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= WAIT_ID;
            cur_id               <= '0;
            flit_idx             <= '0;
            full                 <= 1'b0;
            truncated            <= 1'b0;
            pkt_buffer_write     <= 1'b0;
            pkt_buffer_address   <= '0;
            pkt_buffer_writedata <= '0;
            meta_valid           <= 1'b0;
            meta_data            <= '0;
        end else begin
            pkt_buffer_write <= wr;
            if (wr) begin
                pkt_buffer_address   <= PKTBUF_AWIDTH'({cur_id, widx});
                pkt_buffer_writedata <= {in_pkt_data, in_pkt_sop, in_pkt_eop, in_pkt_empty};
            end
            if (done) begin
                meta_valid <= 1'b1;
                meta_data  <= meta_next;
            end else if (meta_valid && meta_ready) begin
                meta_valid <= 1'b0;
                meta_data  <= '0;
            end
            case (state)
                WAIT_ID: if (emptylist_out_valid) begin
                    cur_id <= emptylist_out_data;
                    state  <= WAIT_SOP;
                end
                WAIT_SOP: if (start) begin
                    flit_idx  <= 5'd1;
                    full      <= 1'b0;
                    truncated <= 1'b0;
                    state     <= in_pkt_eop ? WAIT_ID : BODY;
                end
                BODY: if (accept) begin
                    truncated <= truncated || full;
                    full      <= full || flit_idx == 5'd31;
                    flit_idx  <= (full || flit_idx == 5'd31) ? flit_idx : flit_idx + 5'd1;
                    if (in_pkt_eop) state <= WAIT_ID;
                end
                default: state <= WAIT_ID;
            endcase
        end
    end
endmodule

// File: doc/pkt_buffer_writer.md
PKT_BUFFER_WRITER -- requirements
Module: pkt_buffer_writer

Interface
REQ-001 SHALL have parameter PKT_AWIDTH, default 9; width of a packet ID.
REQ-002 SHALL have parameter PKTBUF_AWIDTH, default 14; packet buffer address width, equal to PKT_AWIDTH+5.
REQ-003 SHALL have ports clk (in, 1), the clock, and rst (in, 1), reset: synchronous, active-high.
REQ-004 SHALL have ports in_pkt_valid, in_pkt_sop, in_pkt_eop (in, 1 each), in_pkt_data (in, 512) and in_pkt_empty (in, 6); the ingress flit stream.
REQ-005 SHALL have port in_pkt_ready (out, 1); the ingress flit is accepted when in_pkt_valid & in_pkt_ready.
REQ-006 SHALL have ports emptylist_out_data (in, PKT_AWIDTH), emptylist_out_valid (in, 1) and emptylist_out_ready (out, 1); these pop free packet IDs.
REQ-007 SHALL have ports pkt_buffer_address (out, PKTBUF_AWIDTH), pkt_buffer_write (out, 1) and pkt_buffer_writedata (out, flit_t); the packet buffer write port.
REQ-008 SHALL have ports meta_valid (out, 1), meta_data (out, metadata_t) and meta_ready (in, 1); the per-packet descriptor.

Function
REQ-009 SHALL implement states WAIT_ID, WAIT_SOP and BODY.
REQ-010 In WAIT_ID, emptylist_out_ready SHALL be 1 and all other states SHALL drive it 0; on emptylist_out_valid the block SHALL latch the ID into cur_id and go to WAIT_SOP.
REQ-011 in_pkt_ready SHALL be 1 only in WAIT_SOP or BODY, and only while meta_valid is 0.
REQ-012 In WAIT_SOP, an accepted flit with sop=0 SHALL be consumed and discarded, with no write.
REQ-013 In WAIT_SOP, an accepted flit with sop=1 SHALL be written at flit index 0.
  - If eop=1 on that flit: packet complete.
  - Otherwise: go to BODY.
REQ-014 In BODY, each accepted flit SHALL be written at the next flit index; an accepted eop SHALL complete the packet, and sop in BODY SHALL be ignored (the flit is treated as data).
REQ-015 Each write SHALL drive the following one cycle after acceptance, with pkt_buffer_write pulsed for exactly 1 cycle per stored flit:
  - pkt_buffer_address = (cur_id<<5) + flit_idx.
  - pkt_buffer_writedata = {data, sop, eop, empty} of the accepted flit.
REQ-016 flit_idx SHALL be 5 bits and SHALL count 0..31 with no wrap.
  - Flits accepted after index 31 SHALL be consumed without a write, and SHALL set a truncated flag.
  - The eop flit itself SHALL be written if flit_idx ≤ 31.
REQ-017 On packet completion, the block SHALL load meta_data one cycle after the eop acceptance, with meta_valid=1:
  - pktID = cur_id.
  - flits = number of stored flits (1..32; the field is wide enough to hold 32).
  - len (16 bit) = stored_flits*64 − eop empty; if truncated, len = 2048.
  - pkt_flags = PKT_DROP if truncated, otherwise PKT_ETH.
  - All other fields = 0.
REQ-018 On packet completion, state SHALL go to WAIT_ID.
REQ-019 meta_valid and meta_data SHALL hold stable until meta_valid & meta_ready, and SHALL clear on the cycle after acceptance.
REQ-020 If emptylist_out_valid and meta_ready events coincide in the same cycle, both SHALL be processed independently in that cycle.
REQ-021 Packet length 1 flit (sop & eop together) SHALL produce flits=1, len=64−empty.
REQ-022 Minimum spacing between eop acceptance and the next sop acceptance SHALL be 2 cycles when the emptylist is valid and meta_ready is 1.
REQ-023 If the emptylist is empty, the block SHALL stay in WAIT_ID with in_pkt_ready=0, applying backpressure with no flit loss.

Reset
REQ-024 While rst=1, the block SHALL drive in_pkt_ready, emptylist_out_ready, pkt_buffer_write and meta_valid to 0, pkt_buffer_address to 0 and meta_data to 0, and SHALL set state to WAIT_ID with flit_idx=0 and the truncated flag cleared.
REQ-025 Reset mid-packet SHALL abandon the packet with no metadata emitted.
  - The held cur_id is lost; reinitialising the emptylist is the system's responsibility.
  - The first cycle after rst deasserts SHALL be in WAIT_ID.

Verification
REQ-026 Emptylist offers ID 5; a 3-flit packet is sent with empty=10 on eop -> writes go to addresses 160, 161, 162; then meta pktID=5, flits=3, len=182, pkt_flags=PKT_ETH, valid 1 cycle after eop.
REQ-027 A single-flit packet with empty=0 and ID 0 -> one write at address 0; meta flits=1, len=64.
REQ-028 A 40-flit packet with ID 2 -> exactly 32 writes at addresses 64..95; meta flits=32, len=2048, pkt_flags=PKT_DROP; all 40 flits are accepted.
REQ-029 meta_ready is held 0 for 10 cycles after a packet, with the next packet pending -> in_pkt_ready stays 0 and meta_data is stable; after meta_ready=1, the next packet is received intact.
REQ-030 The emptylist is empty while a packet is pending -> in_pkt_ready=0 and no writes occur; when ID 7 is offered, the packet is written at address 224 onward.
REQ-031 rst is asserted after 2 flits of a 4-flit packet -> no meta_valid and no further writes; after reset, the block pops a new ID before accepting any flit, and a stray non-sop flit is discarded.
